// File: rtl/mole_timer_array.sv
// Multi-hole whack-a-mole timer: one countdown per hole, fed by a shared 0.1 s
// prescaler, with hit/miss reporting, pause and a live count of raised moles.
module mole_timer_array #(
  parameter int N_MOLES  = 9,
  parameter int TICK_DIV = 10000000,
  parameter int IDX_W    = 4,
  parameter int REM_W    = 6
) (
  input  logic                             CLK100MHZ,
  input  logic                             CPU_RESETN,
  input  logic                             enable,
  input  logic                             pause,
  input  logic [1:0]                       difficulty,
  input  logic                             spawn_valid,
  input  logic [IDX_W-1:0]                 spawn_idx,
  input  logic [2:0]                       spawn_time,
  input  logic [N_MOLES-1:0]               whack,
  output logic [N_MOLES-1:0]               mole_up,
  output logic [N_MOLES-1:0]               hit_pulse,
  output logic [N_MOLES-1:0]               miss_pulse,
  output logic [$clog2(N_MOLES+1)-1:0]     active_count
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(N_MOLES + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic {DOWN, UP} chan_e;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               tick;
  logic [REM_W-1:0]   dur;
  logic               spawnOk;
  chan_e              state_q [N_MOLES];
  chan_e              state_d [N_MOLES];
  logic [REM_W-1:0]   rem_q   [N_MOLES];
  logic [REM_W-1:0]   rem_d   [N_MOLES];
  logic [N_MOLES-1:0] hit_q, hit_d;
  logic [N_MOLES-1:0] miss_q, miss_d;

  // Prescaler freezes during pause so resuming neither loses nor adds a tick.
  always_comb begin
    pre_d = pre_q;
    if (!pause) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    end
  end

  assign tick = !pause && (pre_q == PRE_MAX);

  always_comb begin
    dur = '0;
    case (difficulty)
      2'b00:   dur = REM_W'(26) + REM_W'({spawn_time, 1'b0});
      2'b01:   dur = REM_W'(18) + REM_W'(spawn_time);
      2'b10:   dur = REM_W'(8)  + REM_W'(spawn_time);
      default: dur = REM_W'(4)  + REM_W'(spawn_time);
    endcase
  end

  assign spawnOk = spawn_valid && enable && !pause && (int'(spawn_idx) < N_MOLES);

  // Per-channel priority: disable, spawn (reload, masks whack), whack, timeout.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hit_d   = '0;
    miss_d  = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (!enable) begin
        state_d[i] = DOWN;
        rem_d[i]   = '0;
      end else if (spawnOk && (spawn_idx == IDX_W'(i))) begin
        state_d[i] = UP;
        rem_d[i]   = dur;
      end else if (state_q[i] == UP) begin
        if (whack[i] && !pause) begin
          state_d[i] = DOWN;
          rem_d[i]   = '0;
          hit_d[i]   = 1'b1;
        end else if (tick) begin
          if (rem_q[i] == REM_W'(1)) begin
            state_d[i] = DOWN;
            rem_d[i]   = '0;
            miss_d[i]  = 1'b1;
          end else begin
            rem_d[i] = rem_q[i] - REM_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      pre_q  <= '0;
      hit_q  <= '0;
      miss_q <= '0;
      for (int i = 0; i < N_MOLES; i++) begin
        state_q[i] <= DOWN;
        rem_q[i]   <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    mole_up      = '0;
    active_count = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      mole_up[i]   = (state_q[i] == UP);
      active_count = active_count + CNT_W'(state_q[i] == UP);
    end
  end

  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_timer_array.sv
// Directed bench for mole_timer_array with TICK_DIV=10, N_MOLES=9: timing bounds,
// hit/miss priority, pause freeze and enable drop, checked by immediate assertions.
module tb_mole_timer_array;

  localparam int N  = 9;
  localparam int TD = 10;
  localparam int IW = 4;
  localparam int RW = 6;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          pause;
  logic [1:0]    difficulty;
  logic          spawn_valid;
  logic [IW-1:0] spawn_idx;
  logic [2:0]    spawn_time;
  logic [N-1:0]  whack;
  logic [N-1:0]  mole_up;
  logic [N-1:0]  hit_pulse;
  logic [N-1:0]  miss_pulse;
  logic [CW-1:0] active_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s2, n2, upCnt, guard, c0, c8, m0, m8, badCnt;

  mole_timer_array #(.N_MOLES(N), .TICK_DIV(TD), .IDX_W(IW), .REM_W(RW)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rstn),
    .enable      (enable),
    .pause       (pause),
    .difficulty  (difficulty),
    .spawn_valid (spawn_valid),
    .spawn_idx   (spawn_idx),
    .spawn_time  (spawn_time),
    .whack       (whack),
    .mole_up     (mole_up),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    checks++;
    assert (observed >= lo && observed <= hi)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    end
  endtask

  // One-cycle spawn request; returns at the sample just after the accepting edge.
  task automatic applyStimulus(input logic [1:0] diff, input logic [2:0] k, input logic [IW-1:0] idx);
    difficulty  = diff;
    spawn_time  = k;
    spawn_idx   = idx;
    spawn_valid = 1'b1;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic tallyHoles();
    if (mole_up[0]) c0++;
    if (mole_up[8]) c8++;
    if (miss_pulse[8]) begin
      m8++;
      checkOutput("miss8_active", 32'(active_count), 32'd1);
    end
    if (miss_pulse[0]) begin
      m0++;
      checkOutput("miss0_active", 32'(active_count), 32'd0);
    end
  endtask

  task automatic alignToS2();
    while (((cyc - s2) % TD) != TD - 1) step();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0; enable = 1'b0; pause = 1'b0; difficulty = 2'd0;
    spawn_valid = 1'b0; spawn_idx = '0; spawn_time = 3'd0; whack = '0;
    step();
    step();
    checkOutput("reset_up", 32'(mole_up), 32'd0);
    checkOutput("reset_hit", 32'(hit_pulse), 32'd0);
    checkOutput("reset_miss", 32'(miss_pulse), 32'd0);
    checkOutput("reset_active", 32'(active_count), 32'd0);
    rstn = 1'b1;
    enable = 1'b1;

    // Reset mid-game with three moles raised.
    applyStimulus(2'b10, 3'd0, 4'd0);
    applyStimulus(2'b10, 3'd0, 4'd1);
    applyStimulus(2'b10, 3'd0, 4'd2);
    checkOutput("pre_reset_up", 32'(mole_up), 32'h007);
    checkOutput("pre_reset_active", 32'(active_count), 32'd3);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checkOutput("midreset_up", 32'(mole_up), 32'd0);
    checkOutput("midreset_active", 32'(active_count), 32'd0);
    checkOutput("midreset_miss", 32'(miss_pulse), 32'd0);

    // Hard k=2 (D=10) on hole 4: visible 91..100 cycles then a single miss.
    applyStimulus(2'b10, 3'd2, 4'd4);
    s2 = cyc;
    checkOutput("hard_up", 32'(mole_up), 32'h010);
    upCnt = 1;
    guard = 0;
    while (mole_up[4] && guard < 200) begin
      step();
      guard++;
      if (mole_up[4]) upCnt++;
    end
    n2 = upCnt;
    checkRange("hard_uptime", upCnt, 91, 100);
    checkOutput("hard_miss", 32'(miss_pulse), 32'h010);
    checkOutput("hard_nohit", 32'(hit_pulse), 32'd0);
    checkOutput("hard_active", 32'(active_count), 32'd0);
    step();
    checkOutput("hard_miss_width", 32'(miss_pulse), 32'd0);

    // Easy k=7 (D=40) on hole 0, expert k=0 (D=4) on hole 8 one cycle later.
    c0 = 0; c8 = 0; m0 = 0; m8 = 0;
    applyStimulus(2'b00, 3'd7, 4'd0);
    tallyHoles();
    checkOutput("two_active1", 32'(active_count), 32'd1);
    applyStimulus(2'b11, 3'd0, 4'd8);
    tallyHoles();
    checkOutput("two_active2", 32'(active_count), 32'd2);
    for (int t = 0; t < 450 && mole_up != '0; t++) begin
      step();
      tallyHoles();
    end
    checkRange("expert_uptime", c8, 31, 40);
    checkRange("easy_uptime", c0, 391, 400);
    checkOutput("miss8_count", 32'(m8), 32'd1);
    checkOutput("miss0_count", 32'(m0), 32'd1);
    step();
    checkOutput("miss0_width", 32'(miss_pulse), 32'd0);

    // Medium k=3 on hole 2, whacked 50 cycles in; then a whack on a down hole.
    applyStimulus(2'b01, 3'd3, 4'd2);
    repeat (49) step();
    checkOutput("med_still_up", 32'(mole_up), 32'h004);
    whack = 9'h004;
    step();
    whack = '0;
    checkOutput("med_hit", 32'(hit_pulse), 32'h004);
    checkOutput("med_down", 32'(mole_up), 32'd0);
    checkOutput("med_nomiss", 32'(miss_pulse), 32'd0);
    step();
    checkOutput("med_hit_width", 32'(hit_pulse), 32'd0);
    whack = 9'h008;
    step();
    whack = '0;
    checkOutput("down_whack_nohit", 32'(hit_pulse), 32'd0);
    checkOutput("down_whack_up", 32'(mole_up), 32'd0);
    badCnt = 0;
    repeat (250) begin
      step();
      if (miss_pulse != '0 || hit_pulse != '0) badCnt++;
    end
    checkOutput("med_no_late_pulse", 32'(badCnt), 32'd0);

    // Same prescaler phase as the hard run, so the final tick lands on edge n2.
    alignToS2();
    applyStimulus(2'b10, 3'd2, 4'd4);
    repeat (n2 - 1) step();
    checkOutput("final_tick_still_up", 32'(mole_up), 32'h010);
    whack = 9'h010;
    step();
    whack = '0;
    checkOutput("final_tick_hit", 32'(hit_pulse), 32'h010);
    checkOutput("final_tick_nomiss", 32'(miss_pulse), 32'd0);
    checkOutput("final_tick_down", 32'(mole_up), 32'd0);

    // Spawn and whack together reload hole 1 (D=8) with no hit.
    applyStimulus(2'b10, 3'd0, 4'd1);
    repeat (15) step();
    whack = 9'h002;
    applyStimulus(2'b10, 3'd0, 4'd1);
    whack = '0;
    checkOutput("reload_nohit", 32'(hit_pulse), 32'd0);
    checkOutput("reload_up", 32'(mole_up), 32'h002);
    upCnt = 1;
    guard = 0;
    while (mole_up[1] && guard < 120) begin
      step();
      guard++;
      if (mole_up[1]) upCnt++;
    end
    checkRange("reload_uptime", upCnt, 71, 80);
    checkOutput("reload_miss", 32'(miss_pulse), 32'h002);

    applyStimulus(2'b10, 3'd0, 4'd12);
    checkOutput("idx12_ignored", 32'(mole_up), 32'd0);
    checkOutput("idx12_active", 32'(active_count), 32'd0);

    // Pause for 500 cycles mid-countdown: up time grows by exactly 500.
    alignToS2();
    applyStimulus(2'b10, 3'd2, 4'd4);
    upCnt = 1;
    repeat (29) begin
      step();
      if (mole_up[4]) upCnt++;
    end
    pause = 1'b1;
    badCnt = 0;
    for (int t = 0; t < 500; t++) begin
      whack       = (t == 100) ? 9'h010 : 9'h000;
      spawn_valid = (t == 200);
      spawn_idx   = 4'd6;
      step();
      if (mole_up[4]) upCnt++;
      if (mole_up != 9'h010 || hit_pulse != '0 || miss_pulse != '0) badCnt++;
    end
    pause = 1'b0;
    whack = '0;
    spawn_valid = 1'b0;
    checkOutput("pause_held", 32'(badCnt), 32'd0);
    guard = 0;
    while (mole_up[4] && guard < 200) begin
      step();
      guard++;
      if (mole_up[4]) upCnt++;
    end
    checkOutput("pause_uptime", 32'(upCnt), 32'(n2 + 500));
    checkOutput("pause_miss", 32'(miss_pulse), 32'h010);

    // Enable drop with four moles up clears everything silently.
    applyStimulus(2'b10, 3'd0, 4'd0);
    applyStimulus(2'b10, 3'd0, 4'd1);
    applyStimulus(2'b10, 3'd0, 4'd2);
    applyStimulus(2'b10, 3'd0, 4'd3);
    checkOutput("four_active", 32'(active_count), 32'd4);
    enable = 1'b0;
    step();
    checkOutput("disable_up", 32'(mole_up), 32'd0);
    checkOutput("disable_miss", 32'(miss_pulse), 32'd0);
    checkOutput("disable_hit", 32'(hit_pulse), 32'd0);
    checkOutput("disable_active", 32'(active_count), 32'd0);
    applyStimulus(2'b10, 3'd0, 4'd5);
    checkOutput("disabled_spawn_ignored", 32'(mole_up), 32'd0);
    checkOutput("disable_miss_later", 32'(miss_pulse), 32'd0);
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
